// File: rtl/axi_mem_slave_if.sv
// AXI4 memory-mapped bus bundle for axi_mem_slave: AW/W/B write channels, AR/R read channels.
interface axi_mem_slave_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] s_axi_awaddr;
    logic [7:0]        s_axi_awlen;
    logic [2:0]        s_axi_awsize;
    logic [1:0]        s_axi_awburst;
    logic [3:0]        s_axi_awcache;
    logic [2:0]        s_axi_awprot;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [DATA_W-1:0] s_axi_wdata;
    logic [STRB_W-1:0] s_axi_wstrb;
    logic              s_axi_wlast;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [7:0]        s_axi_arlen;
    logic [2:0]        s_axi_arsize;
    logic [1:0]        s_axi_arburst;
    logic [3:0]        s_axi_arcache;
    logic [2:0]        s_axi_arprot;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awcache, s_axi_awprot,
               s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arcache, s_axi_arprot,
               s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awcache, s_axi_awprot,
               s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arcache, s_axi_arprot,
               s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
    );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 word-addressed RAM responder with independent read and write burst engines.
// Optional AXI_MEM_RANGE_CHECK_EN: out-of-range beats get SLVERR instead of wrapping.
module axi_mem_slave #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 64
) (
    input  logic            s_axi_aclk,
    input  logic            s_axi_areset,
    axi_mem_slave_if.slave  axi
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    typedef enum logic       {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    r_state_t          r_state;
    logic [ADDR_W-1:0] r_addr, r_next;
    logic [7:0]        r_len, r_cnt;
    logic [1:0]        r_burst;

    w_state_t          w_state;
    logic [ADDR_W-1:0] w_addr, w_next;
    logic [7:0]        w_len, w_cnt;
    logic [1:0]        w_burst;
    logic              w_err, w_err_next, w_fire;
    logic              ar_oor, rn_oor, w_oor;

    // FIXED holds the address; INCR and WRAP both step one full-width word per beat
    assign r_next = (r_burst == 2'b00) ? r_addr : r_addr + ADDR_W'(STRB_W);
    assign w_next = (w_burst == 2'b00) ? w_addr : w_addr + ADDR_W'(STRB_W);

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign ar_oor = |axi.s_axi_araddr[ADDR_W-1:OFF_W+IDX_W];
    assign rn_oor = |r_next[ADDR_W-1:OFF_W+IDX_W];
    assign w_oor  = |w_addr[ADDR_W-1:OFF_W+IDX_W];
`else
    assign ar_oor = 1'b0;
    assign rn_oor = 1'b0;
    assign w_oor  = 1'b0;
`endif

    assign w_fire     = (w_state == W_DATA) && axi.s_axi_wvalid && axi.s_axi_wready;
    assign w_err_next = w_err | (axi.s_axi_wlast != (w_cnt == w_len)) | w_oor;

    logic unused_ok;
    assign unused_ok = ^{axi.s_axi_awsize, axi.s_axi_arsize, axi.s_axi_awcache, axi.s_axi_awprot,
                         axi.s_axi_arcache, axi.s_axi_arprot, axi.s_axi_awaddr, axi.s_axi_araddr,
                         r_addr, w_addr, r_next, w_next};

    // RAM is deliberately not cleared by reset
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_areset && w_fire && !w_oor)
            for (int i = 0; i < STRB_W; i++)
                if (axi.s_axi_wstrb[i])
                    mem[w_addr[OFF_W +: IDX_W]][8*i +: 8] <= axi.s_axi_wdata[8*i +: 8];
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state           <= R_IDLE;
            r_addr            <= '0;
            r_len             <= '0;
            r_cnt             <= '0;
            r_burst           <= '0;
            axi.s_axi_arready <= 1'b0;
            axi.s_axi_rvalid  <= 1'b0;
            axi.s_axi_rlast   <= 1'b0;
            axi.s_axi_rdata   <= '0;
            axi.s_axi_rresp   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    axi.s_axi_arready <= 1'b1;
                    if (axi.s_axi_arvalid && axi.s_axi_arready) begin
                        r_addr            <= axi.s_axi_araddr;
                        r_len             <= axi.s_axi_arlen;
                        r_burst           <= axi.s_axi_arburst;
                        r_cnt             <= '0;
                        axi.s_axi_arready <= 1'b0;
                        axi.s_axi_rdata   <= ar_oor ? '0 : mem[axi.s_axi_araddr[OFF_W +: IDX_W]];
                        axi.s_axi_rresp   <= ar_oor ? 2'b10 : 2'b00;
                        axi.s_axi_rvalid  <= 1'b1;
                        axi.s_axi_rlast   <= (axi.s_axi_arlen == 8'd0);
                        r_state           <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi.s_axi_rvalid && axi.s_axi_rready) begin
                        if (r_cnt == r_len) begin
                            axi.s_axi_rvalid  <= 1'b0;
                            axi.s_axi_rlast   <= 1'b0;
                            axi.s_axi_arready <= 1'b1;
                            r_state           <= R_IDLE;
                        end else begin
                            r_cnt           <= r_cnt + 8'd1;
                            r_addr          <= r_next;
                            axi.s_axi_rdata <= rn_oor ? '0 : mem[r_next[OFF_W +: IDX_W]];
                            axi.s_axi_rresp <= rn_oor ? 2'b10 : 2'b00;
                            axi.s_axi_rlast <= (r_cnt + 8'd1 == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state           <= W_IDLE;
            w_addr            <= '0;
            w_len             <= '0;
            w_cnt             <= '0;
            w_burst           <= '0;
            w_err             <= 1'b0;
            axi.s_axi_awready <= 1'b0;
            axi.s_axi_wready  <= 1'b0;
            axi.s_axi_bvalid  <= 1'b0;
            axi.s_axi_bresp   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    axi.s_axi_awready <= 1'b1;
                    if (axi.s_axi_awvalid && axi.s_axi_awready) begin
                        w_addr            <= axi.s_axi_awaddr;
                        w_len             <= axi.s_axi_awlen;
                        w_burst           <= axi.s_axi_awburst;
                        w_cnt             <= '0;
                        w_err             <= 1'b0;
                        axi.s_axi_awready <= 1'b0;
                        axi.s_axi_wready  <= 1'b1;
                        w_state           <= W_DATA;
                    end
                end
                W_DATA: begin
                    // the beat count, not wlast, terminates the burst; a misplaced wlast only flags SLVERR
                    if (w_fire) begin
                        w_err <= w_err_next;
                        if (w_cnt == w_len) begin
                            axi.s_axi_wready <= 1'b0;
                            axi.s_axi_bvalid <= 1'b1;
                            axi.s_axi_bresp  <= w_err_next ? 2'b10 : 2'b00;
                            w_state          <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= w_next;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.s_axi_bready) begin
                        axi.s_axi_bvalid  <= 1'b0;
                        axi.s_axi_awready <= 1'b1;
                        w_state           <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: reset, bursts, strobes, stalls, wlast errors, range, mid-burst reset.
module tb_axi_mem_slave;
    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 32;
    localparam int MEM_DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_mem_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) axi ();

    axi_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .axi          (axi)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] model [MEM_DEPTH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_hs(input logic [31:0] addr, input logic [7:0] len);
        int t;
        axi.s_axi_awaddr  = addr;
        axi.s_axi_awlen   = len;
        axi.s_axi_awburst = 2'b01;
        axi.s_axi_awsize  = 3'd3;
        axi.s_axi_awvalid = 1'b1;
        for (t = 0; !axi.s_axi_awready && t < 64; t++) tick();
        if (!axi.s_axi_awready) chk("aw_timeout", 64'd0, 64'd1);
        tick();
        axi.s_axi_awvalid = 1'b0;
    endtask

    task automatic ar_hs(input logic [31:0] addr, input logic [7:0] len);
        int t;
        axi.s_axi_araddr  = addr;
        axi.s_axi_arlen   = len;
        axi.s_axi_arburst = 2'b01;
        axi.s_axi_arsize  = 3'd3;
        axi.s_axi_arvalid = 1'b1;
        for (t = 0; !axi.s_axi_arready && t < 64; t++) tick();
        if (!axi.s_axi_arready) chk("ar_timeout", 64'd0, 64'd1);
        tick();
        axi.s_axi_arvalid = 1'b0;
    endtask

    // data for beat i is base+i; wlast driven only on beat last_at
    task automatic wr_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [63:0] base, input logic [7:0] strb, input int last_at,
                            output logic [1:0] resp);
        int t;
        int idx;
        logic [63:0] d;
        aw_hs(addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            d = base + 64'(i);
            axi.s_axi_wdata  = d;
            axi.s_axi_wstrb  = strb;
            axi.s_axi_wlast  = (i == last_at);
            axi.s_axi_wvalid = 1'b1;
            for (t = 0; !axi.s_axi_wready && t < 64; t++) tick();
            if (i > last_at) chk({tag, "_wready_hold"}, 64'(axi.s_axi_wready), 64'd1);
            else if (!axi.s_axi_wready) chk({tag, "_w_timeout"}, 64'd0, 64'd1);
            tick();
            idx = (int'(addr >> 3) + i) % MEM_DEPTH;
            for (int k = 0; k < 8; k++)
                if (strb[k]) model[idx][8*k +: 8] = d[8*k +: 8];
        end
        axi.s_axi_wvalid = 1'b0;
        axi.s_axi_wlast  = 1'b0;
        chk({tag, "_bvalid"}, 64'(axi.s_axi_bvalid), 64'd1);
        chk({tag, "_wready_off"}, 64'(axi.s_axi_wready), 64'd0);
        resp = axi.s_axi_bresp;
        axi.s_axi_bready = 1'b1;
        tick();
        axi.s_axi_bready = 1'b0;
        chk({tag, "_bvalid_clr"}, 64'(axi.s_axi_bvalid), 64'd0);
    endtask

    // stall=1 drives rready 1,0,0,1,0,0...; rst_at>=0 asserts reset while beat rst_at is presented
    task automatic rd_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input bit stall, input bit oor, input int rst_at,
                            output logic [63:0] last_data);
        int b;
        int cyc;
        logic [63:0] exp;
        ar_hs(addr, len);
        b = 0;
        cyc = 0;
        last_data = '0;
        while (b <= int'(len) && cyc < 200) begin
            exp = oor ? 64'd0 : model[(int'(addr >> 3) + b) % MEM_DEPTH];
            chk({tag, "_rvalid"}, 64'(axi.s_axi_rvalid), 64'd1);
            chk({tag, "_rdata"}, axi.s_axi_rdata, exp);
            chk({tag, "_rlast"}, 64'(axi.s_axi_rlast), 64'(b == int'(len)));
            chk({tag, "_rresp"}, 64'(axi.s_axi_rresp), oor ? 64'd2 : 64'd0);
            last_data = axi.s_axi_rdata;
            if (b == rst_at) begin
                rst = 1'b1;
                tick();
                chk({tag, "_rst_rvalid"}, 64'(axi.s_axi_rvalid), 64'd0);
                rst = 1'b0;
                axi.s_axi_rready = 1'b0;
                tick();
                chk({tag, "_rst_arready"}, 64'(axi.s_axi_arready), 64'd1);
                chk({tag, "_rst_awready"}, 64'(axi.s_axi_awready), 64'd1);
                chk({tag, "_rst_rvalid2"}, 64'(axi.s_axi_rvalid), 64'd0);
                return;
            end
            axi.s_axi_rready = !stall || (cyc % 3 == 0);
            tick();
            if (axi.s_axi_rready) b++;
            cyc++;
        end
        if (cyc >= 200) chk({tag, "_r_timeout"}, 64'd0, 64'd1);
        axi.s_axi_rready = 1'b0;
        chk({tag, "_rvalid_end"}, 64'(axi.s_axi_rvalid), 64'd0);
        chk({tag, "_arready_end"}, 64'(axi.s_axi_arready), 64'd1);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [63:0] rd;
        bit          rc_en;
`ifdef AXI_MEM_RANGE_CHECK_EN
        rc_en = 1'b1;
`else
        rc_en = 1'b0;
`endif
        for (int i = 0; i < MEM_DEPTH; i++) model[i] = '0;
        axi.s_axi_awaddr = '0;  axi.s_axi_awlen = '0;  axi.s_axi_awsize = '0;
        axi.s_axi_awburst = '0; axi.s_axi_awcache = '0; axi.s_axi_awprot = '0;
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata = '0;   axi.s_axi_wstrb = '0;  axi.s_axi_wlast = 1'b0;
        axi.s_axi_wvalid = 1'b0; axi.s_axi_bready = 1'b0;
        axi.s_axi_araddr = '0;  axi.s_axi_arlen = '0;  axi.s_axi_arsize = '0;
        axi.s_axi_arburst = '0; axi.s_axi_arcache = '0; axi.s_axi_arprot = '0;
        axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_arready", 64'(axi.s_axi_arready), 64'd0);
        chk("rst_awready", 64'(axi.s_axi_awready), 64'd0);
        chk("rst_wready",  64'(axi.s_axi_wready),  64'd0);
        chk("rst_bvalid",  64'(axi.s_axi_bvalid),  64'd0);
        chk("rst_rvalid",  64'(axi.s_axi_rvalid),  64'd0);
        chk("rst_rlast",   64'(axi.s_axi_rlast),   64'd0);
        chk("rst_rdata",   axi.s_axi_rdata,        64'd0);
        chk("rst_bresp",   64'(axi.s_axi_bresp),   64'd0);
        chk("rst_rresp",   64'(axi.s_axi_rresp),   64'd0);
        rst = 1'b0;
        tick();
        chk("rel_arready", 64'(axi.s_axi_arready), 64'd1);
        chk("rel_awready", 64'(axi.s_axi_awready), 64'd1);
        chk("rel_bvalid",  64'(axi.s_axi_bvalid),  64'd0);
        chk("rel_rvalid",  64'(axi.s_axi_rvalid),  64'd0);

        // 16-beat write then read-back of data=i
        wr_burst("t2w", 32'h20, 8'd15, 64'd0, 8'hFF, 15, resp);
        chk("t2_bresp", 64'(resp), 64'd0);
        rd_burst("t2r", 32'h20, 8'd15, 1'b0, 1'b0, -1, rd);
        chk("t2_last_word", rd, 64'd15);

        // partial strobe over a cleared word
        wr_burst("t3a", 32'h0, 8'd0, 64'd0, 8'hFF, 0, resp);
        chk("t3a_bresp", 64'(resp), 64'd0);
        wr_burst("t3b", 32'h0, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, resp);
        chk("t3b_bresp", 64'(resp), 64'd0);
        rd_burst("t3r", 32'h0, 8'd0, 1'b0, 1'b0, -1, rd);
        chk("t3_strb_word", rd, 64'h0000_0000_FFFF_FFFF);

        // rready stalls: data/last must hold while stalled
        rd_burst("t4r", 32'h20, 8'd7, 1'b1, 1'b0, -1, rd);
        chk("t4_last_word", rd, 64'd7);

        // early wlast: burst still runs 8 beats, response is SLVERR
        wr_burst("t5w", 32'h100, 8'd7, 64'h500, 8'hFF, 3, resp);
        chk("t5_bresp", 64'(resp), 64'd2);
        rd_burst("t5r", 32'h100, 8'd7, 1'b0, 1'b0, -1, rd);
        chk("t5_last_word", rd, 64'h507);

        // address one past the array
        rd_burst("t6r", 32'h200, 8'd0, 1'b0, rc_en, -1, rd);
        chk("t6_word", rd, rc_en ? 64'd0 : 64'h0000_0000_FFFF_FFFF);

        // reset while beat 5 of a 16-beat read is on the bus
        rd_burst("t7r", 32'h20, 8'd15, 1'b0, 1'b0, 5, rd);
        chk("t7_beat5", rd, 64'd5);
        tick();
        chk("t7_idle_rvalid", 64'(axi.s_axi_rvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
